kyber_butterfly: RTL and testbench
==================================

# kyber_butterfly

Pipelined modular butterfly unit for the Kyber NTT datapath (q = 3329). Each cycle it accepts one coefficient pair (a, b) and one twiddle w, and performs one of four operations selected by mode. The operations are a Cooley-Tukey forward butterfly, a Gentleman-Sande inverse butterfly, a dual scalar multiply and a plain add/subtract. Two reduced coefficients (c, d) are produced a fixed number of cycles later. It sits between the coefficient RAM read ports and the write-back path of the NTT/INTT controller.

## Interface
- Q, 3329: Kyber modulus.
- W, 16: coefficient and twiddle width.
- LAT, 3: pipeline latency in cycles; fixed, not user-tunable.

- clk  in  1  rising-edge clock; the block uses this single clock only.
- rst_n  in  1  synchronous, active-low reset.
- a  in  16  first coefficient; any 16-bit value is accepted.
- b  in  16  second coefficient; any 16-bit value is accepted.
- w  in  16  twiddle or scale factor; any 16-bit value is accepted.
- mode  in  2  operation select, sampled together with a, b and w.
- c  out  16  first result, always in [0, Q-1].
- d  out  16  second result, always in [0, Q-1].

## Operation
- Input conditioning: a, b and w are each reduced mod Q before use, giving a', b' and w'. Example: 0xFFEE (65518) reduces to 2267.
- Mode 00 (NTT, Cooley-Tukey):
  - t = b'·w' mod Q
  - c = (a' + t) mod Q
  - d = (a' − t) mod Q
- Mode 01 (INTT, Gentleman-Sande):
  - c = (a' + b') mod Q
  - d = ((a' − b') mod Q)·w' mod Q
  - No halving step; the controller applies n⁻¹ scaling separately through mode 10.
- Mode 10 (scale):
  - c = a'·w' mod Q
  - d = b'·w' mod Q
- Mode 11 (add/sub):
  - c = (a' + b') mod Q
  - d = (a' − b') mod Q
- Arithmetic rules:
  - Products are 24-bit (12b × 12b) and reduced with Barrett reduction, followed by at most one conditional subtract of Q.
  - Additions use one conditional subtract of Q.
  - Subtractions add Q when the difference is negative.
  - Results are never equal to Q and never negative.
- Results depend only on the inputs sampled LAT cycles earlier; the block holds no state across operations.

## Timing
- Fully pipelined: accepts a new (a, b, w, mode) every cycle with no stalls and no handshake.
- Inputs sampled at rising edge N produce c and d that are valid after rising edge N+3.
- mode travels down the pipeline with its operands, so mixing modes on consecutive cycles is legal.
- Pipeline stages:
  - S1: register the reduced inputs and mode.
  - S2: mode-dependent pre-add/sub and multiplier operand select, then multiply and Barrett reduce.
  - S3: post-add/sub, then register c and d.
- Reset:
  - While rst_n = 0 at a rising edge, every pipeline register and both outputs clear to 0.
  - Asserting reset mid-stream discards all in-flight operations.
  - After rst_n rises, the outputs stay 0 until the first post-reset operation emerges 3 cycles later.
- Outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Shared package kyber_pkg contains:
  - Q = 3329
  - W = 16
  - the Barrett constant for Q, which is ⌊2^24/Q⌋ = 5039 with a 24-bit shift
  - the enum mode_t = {MODE_NTT = 2'b00, MODE_INTT = 2'b01, MODE_SCALE = 2'b10, MODE_ADDSUB = 2'b11}
- Sub-module mod_mul_q: a 12×12 multiply plus Barrett reduction.
  - Two instances are needed: one for the t or (a'−b')·w' product, one for b'·w' in mode 10.
  - The 16-bit input pre-reduction reuses the same Barrett logic as mod_mul_q.

## Test plan
- NTT: a=0x00FF, b=0xFFEE, w=0x0010, mode=00 → 3 cycles later c=3237 (0x0CA5), d=602 (0x025A).
- INTT: a=0x0CA5, b=0x025A, w=3121, mode=01 → c=510, d=1205.
- Scale and add/sub:
  - a=1, b=2, w=3303, mode=10 → c=3303, d=3277.
  - a=3328, b=1, mode=11 → c=0, d=3327.
- Back-to-back: issue the NTT vector then the INTT vector on consecutive cycles → results appear on consecutive cycles at N+3 and N+4, and each is correct for its own mode.
- Reset: hold rst_n=0 for 2 cycles during streaming → c=d=0 while reset is held and for 3 cycles after it releases; the first valid result appears at release+3.
- Random sweep: 10k random a, b, w and mode values checked against a golden model → outputs match exactly and are always < 3329.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared constants, mode encoding and modular helpers for the Kyber butterfly datapath.
// barrett_reduce is used for both the 16-bit input conditioning and the 12x12 product reduction.
package kyber_pkg;

  localparam int Q         = 3329;
  localparam int W         = 16;
  localparam int LAT       = 3;
  localparam int BARRETT_M = 5039;
  localparam int BARRETT_K = 24;

  typedef enum logic [1:0] {
    MODE_NTT    = 2'b00,
    MODE_INTT   = 2'b01,
    MODE_SCALE  = 2'b10,
    MODE_ADDSUB = 2'b11
  } mode_t;

  // For x < 2^24 the quotient estimate is low by at most one, so one subtract suffices.
  function automatic logic [11:0] barrett_reduce(input logic [23:0] x);
    logic [36:0] prod;
    logic [12:0] quot;
    logic [25:0] qq;
    logic [23:0] rem;
    prod = {13'd0, x} * 37'(BARRETT_M);
    quot = prod[BARRETT_K +: 13];
    qq   = {13'd0, quot} * 26'(Q);
    rem  = x - qq[23:0];
    if (rem >= 24'(Q)) rem = rem - 24'(Q);
    return rem[11:0];
  endfunction

  function automatic logic [11:0] mod_add(input logic [11:0] x, input logic [11:0] y);
    logic [12:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= 13'(Q)) s = s - 13'(Q);
    return s[11:0];
  endfunction

  function automatic logic [11:0] mod_sub(input logic [11:0] x, input logic [11:0] y);
    logic [12:0] s;
    s = {1'b0, x} - {1'b0, y};
    if (x < y) s = s + 13'(Q);
    return s[11:0];
  endfunction

endpackage

// File: rtl/kyber_butterfly_mod_mul_q.sv
// Combinational 12x12 modular multiplier: full 24-bit product followed by Barrett reduction mod Q.
module mod_mul_q
  import kyber_pkg::*;
(
  input  logic [11:0] x,
  input  logic [11:0] y,
  output logic [11:0] r
);

  logic [23:0] prod;

  assign prod = {12'd0, x} * {12'd0, y};
  assign r    = barrett_reduce(prod);

endmodule

// File: rtl/kyber_butterfly.sv
// Pipelined Kyber butterfly: reduced-input register, operand select, modular multiply, post add/sub.
// Operands sampled at edge N appear on c/d after edge N+3; mode travels with its operands.
module kyber_butterfly
  import kyber_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] w,
  input  logic [1:0]   mode,
  output logic [W-1:0] c,
  output logic [W-1:0] d
);

  logic [11:0] a_red, b_red, w_red;
  mode_t       mode_in;

  logic [11:0] s1_a, s1_b, s1_w;
  mode_t       s1_mode;

  logic [11:0] pre_sum, pre_diff, pre_x0;

  logic [11:0] s2_a, s2_b, s2_w, s2_sum, s2_diff, s2_x0;
  mode_t       s2_mode;

  logic [11:0] p0, p1;

  logic [11:0] s3_a, s3_sum, s3_diff, s3_p0, s3_p1;
  mode_t       s3_mode;

  logic [11:0] c_next, d_next;

  assign mode_in = mode_t'(mode);
  assign a_red   = barrett_reduce({8'd0, a});
  assign b_red   = barrett_reduce({8'd0, b});
  assign w_red   = barrett_reduce({8'd0, w});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_a    <= '0;
      s1_b    <= '0;
      s1_w    <= '0;
      s1_mode <= MODE_NTT;
    end else begin
      s1_a    <= a_red;
      s1_b    <= b_red;
      s1_w    <= w_red;
      s1_mode <= mode_in;
    end
  end

  // Multiplier 0 carries the mode-dependent product; multiplier 1 always forms b'*w'.
  always_comb begin
    pre_sum  = mod_add(s1_a, s1_b);
    pre_diff = mod_sub(s1_a, s1_b);
    pre_x0   = s1_b;
    case (s1_mode)
      MODE_NTT:   pre_x0 = s1_b;
      MODE_INTT:  pre_x0 = pre_diff;
      MODE_SCALE: pre_x0 = s1_a;
      default:    pre_x0 = s1_a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_a    <= '0;
      s2_b    <= '0;
      s2_w    <= '0;
      s2_sum  <= '0;
      s2_diff <= '0;
      s2_x0   <= '0;
      s2_mode <= MODE_NTT;
    end else begin
      s2_a    <= s1_a;
      s2_b    <= s1_b;
      s2_w    <= s1_w;
      s2_sum  <= pre_sum;
      s2_diff <= pre_diff;
      s2_x0   <= pre_x0;
      s2_mode <= s1_mode;
    end
  end

  mod_mul_q u_mul0 (
    .x (s2_x0),
    .y (s2_w),
    .r (p0)
  );

  mod_mul_q u_mul1 (
    .x (s2_b),
    .y (s2_w),
    .r (p1)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s3_a    <= '0;
      s3_sum  <= '0;
      s3_diff <= '0;
      s3_p0   <= '0;
      s3_p1   <= '0;
      s3_mode <= MODE_NTT;
    end else begin
      s3_a    <= s2_a;
      s3_sum  <= s2_sum;
      s3_diff <= s2_diff;
      s3_p0   <= p0;
      s3_p1   <= p1;
      s3_mode <= s2_mode;
    end
  end

  always_comb begin
    c_next = s3_sum;
    d_next = s3_diff;
    case (s3_mode)
      MODE_NTT: begin
        c_next = mod_add(s3_a, s3_p0);
        d_next = mod_sub(s3_a, s3_p0);
      end
      MODE_INTT: begin
        c_next = s3_sum;
        d_next = s3_p0;
      end
      MODE_SCALE: begin
        c_next = s3_p0;
        d_next = s3_p1;
      end
      default: begin
        c_next = s3_sum;
        d_next = s3_diff;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c <= '0;
      d <= '0;
    end else begin
      c <= {4'd0, c_next};
      d <= {4'd0, d_next};
    end
  end

endmodule

// File: tb/tb_kyber_butterfly.sv
// Scoreboard bench for kyber_butterfly: stimulus pushes expected (c, d) tagged with the cycle they
// are due; a negedge monitor pops and compares independently of the stimulus thread.
module tb_kyber_butterfly;

  localparam int QM  = 3329;
  localparam int LATENCY = 3;

  typedef struct {
    int          due;
    logic [15:0] c;
    logic [15:0] d;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] a, b, w;
  logic [1:0]  mode;
  logic [15:0] c, d;

  exp_t sb[$];
  exp_t monEntry;
  int   cycle = 0;
  int   tests = 0;
  int   fails = 0;

  kyber_butterfly dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .w     (w),
    .mode  (mode),
    .c     (c),
    .d     (d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Independent reference using plain integer remainder arithmetic.
  function automatic void golden(input logic [15:0] ia, input logic [15:0] ib, input logic [15:0] iw,
                                 input logic [1:0] im, output logic [15:0] ec, output logic [15:0] ed);
    int ar, br, wr, t, cc, dd;
    ar = int'(ia) % QM;
    br = int'(ib) % QM;
    wr = int'(iw) % QM;
    case (im)
      2'b00: begin
        t  = (br * wr) % QM;
        cc = (ar + t) % QM;
        dd = (ar - t + QM) % QM;
      end
      2'b01: begin
        cc = (ar + br) % QM;
        dd = (((ar - br + QM) % QM) * wr) % QM;
      end
      2'b10: begin
        cc = (ar * wr) % QM;
        dd = (br * wr) % QM;
      end
      default: begin
        cc = (ar + br) % QM;
        dd = (ar - br + QM) % QM;
      end
    endcase
    ec = 16'(cc);
    ed = 16'(dd);
  endfunction

  task automatic checkOutput(input exp_t e);
    tests++;
    if (c !== e.c) begin
      fails++;
      $display("[TB] FAIL %s c: got %0d, expected %0d (cycle %0d)", e.name, c, e.c, cycle);
    end
    tests++;
    if (d !== e.d) begin
      fails++;
      $display("[TB] FAIL %s d: got %0d, expected %0d (cycle %0d)", e.name, d, e.d, cycle);
    end
    tests++;
    if ($isunknown({c, d}) || c >= 16'(QM) || d >= 16'(QM)) begin
      fails++;
      $display("[TB] FAIL %s range: got c=%0d d=%0d, expected both below %0d", e.name, c, d, QM);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      if (sb[0].due < cycle) begin
        monEntry = sb.pop_front();
        tests++;
        fails++;
        $display("[TB] FAIL %s missed: due cycle %0d, now cycle %0d", monEntry.name, monEntry.due, cycle);
      end else if (sb[0].due == cycle) begin
        monEntry = sb.pop_front();
        checkOutput(monEntry);
      end
    end
  end

  // Called #1 after a rising edge; drives one operation and advances to the next cycle.
  task automatic applyStimulus(input logic [15:0] ia, input logic [15:0] ib, input logic [15:0] iw,
                               input logic [1:0] im, input logic [15:0] ec, input logic [15:0] ed,
                               input string nm);
    exp_t e;
    a    = ia;
    b    = ib;
    w    = iw;
    mode = im;
    e.due  = cycle + 1 + LATENCY;
    e.c    = ec;
    e.d    = ed;
    e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // In-flight expectations are dropped; outputs must read zero during reset and for LATENCY cycles after.
  task automatic holdReset(input int n);
    exp_t keep[$];
    exp_t e;
    foreach (sb[i]) if (sb[i].due <= cycle) keep.push_back(sb[i]);
    sb = keep;
    rst_n = 1'b0;
    for (int i = 1; i <= n + LATENCY; i++) begin
      e.due  = cycle + i;
      e.c    = 16'd0;
      e.d    = 16'd0;
      e.name = "reset_zero";
      sb.push_back(e);
    end
    repeat (n) begin
      a    = 16'($urandom);
      b    = 16'($urandom);
      w    = 16'($urandom);
      mode = 2'($urandom);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] ra, rb, rw, ec, ed;
    logic [1:0]  rm;
    int          waitCycles;
    rst_n = 1'b0;
    a = '0; b = '0; w = '0; mode = '0;
    @(posedge clk);
    #1;
    holdReset(2);

    applyStimulus(16'h00FF, 16'hFFEE, 16'h0010, 2'b00, 16'd3237, 16'd602,  "ntt");
    applyStimulus(16'h0CA5, 16'h025A, 16'd3121, 2'b01, 16'd510,  16'd1205, "intt");
    applyStimulus(16'd1,    16'd2,    16'd3303, 2'b10, 16'd3303, 16'd3277, "scale");
    applyStimulus(16'd3328, 16'd1,    16'd0,    2'b11, 16'd0,    16'd3327, "addsub");
    applyStimulus(16'd3329, 16'd3329, 16'd5,    2'b11, 16'd0,    16'd0,    "addsub_q");
    applyStimulus(16'd0,    16'd1,    16'd3328, 2'b00, 16'd3328, 16'd1,    "ntt_wrap");
    applyStimulus(16'hFFFF, 16'd0,    16'd2,    2'b10, 16'd1239, 16'd0,    "scale_max");
    applyStimulus(16'd0,    16'd1,    16'd1,    2'b01, 16'd1,    16'd3328, "intt_neg");

    applyStimulus(16'h00FF, 16'hFFEE, 16'h0010, 2'b00, 16'd3237, 16'd602,  "flushed");
    applyStimulus(16'h0CA5, 16'h025A, 16'd3121, 2'b01, 16'd510,  16'd1205, "flushed");
    holdReset(2);
    applyStimulus(16'd3328, 16'd1,    16'd0,    2'b11, 16'd0,    16'd3327, "post_reset");
    applyStimulus(16'h00FF, 16'hFFEE, 16'h0010, 2'b00, 16'd3237, 16'd602,  "ntt_after");

    for (int i = 0; i < 10000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rw = 16'($urandom);
      rm = 2'($urandom);
      golden(ra, rb, rw, rm, ec, ed);
      applyStimulus(ra, rb, rw, rm, ec, ed, "sweep");
    end

    waitCycles = 0;
    while (sb.size() > 0 && waitCycles < 20) begin
      @(posedge clk);
      #1;
      waitCycles++;
    end
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain: %0d results outstanding, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
